// File: rtl/banco_nos_ativos.sv
// banco_nos_ativos: register bank with one address and one active flag per node slot.
// It waits for the manager's one-hot slot enable after an update or deactivate request.
// It then writes or clears that slot, or reports an error or a timeout.
module banco_nos_ativos #(
    parameter int NUM_NA    = 8,
    parameter int ADR_WIDTH = 5,
    parameter int TIMEOUT   = 15,
    parameter int TO_WIDTH  = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          atualizar_in,
    input  logic                          desativar_in,
    input  logic [ADR_WIDTH-1:0]          endereco_in,
    input  logic [NUM_NA-1:0]             habilitar_in,
    output logic [ADR_WIDTH*NUM_NA-1:0]   na_endereco_out,
    output logic [NUM_NA-1:0]             na_ativo_out,
    output logic [CNT_WIDTH-1:0]          num_ativos_out,
    output logic                          cheio_out,
    output logic                          ocupado_out,
    output logic                          concluido_out,
    output logic                          erro_out
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ESPERA_ATU = 2'd1,
        ST_ESPERA_DES = 2'd2
    } estado_t;

    localparam logic [TO_WIDTH-1:0]  TO_MAX  = TO_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(NUM_NA);

    estado_t                       estado_q, estado_d;
    logic [ADR_WIDTH-1:0]          adr_reg_q, adr_reg_d;
    logic [TO_WIDTH-1:0]           cnt_to_q, cnt_to_d;
    logic [ADR_WIDTH*NUM_NA-1:0]   na_end_q, na_end_d;
    logic [NUM_NA-1:0]             na_ativo_q, na_ativo_d;
    logic [CNT_WIDTH-1:0]          num_ativos_q, num_ativos_d;
    logic                          ocupado_q, ocupado_d;
    logic                          concluido_q, concluido_d;
    logic                          erro_q, erro_d;

    logic                          slot_ativo;
    logic                          slot_igual;

    // Look up the slot selected by the enable (meaningful only when it is one-hot)
    always_comb begin
        slot_ativo = 1'b0;
        slot_igual = 1'b0;
        for (int i = 0; i < NUM_NA; i++) begin
            if (habilitar_in[i]) begin
                slot_ativo = na_ativo_q[i];
                slot_igual = (na_end_q[ADR_WIDTH*i +: ADR_WIDTH] == adr_reg_q);
            end
        end
    end

    // Request FSM plus slot-bank next state; pulses default low every cycle
    always_comb begin
        estado_d     = estado_q;
        adr_reg_d    = adr_reg_q;
        cnt_to_d     = cnt_to_q;
        na_end_d     = na_end_q;
        na_ativo_d   = na_ativo_q;
        num_ativos_d = num_ativos_q;
        concluido_d  = 1'b0;
        erro_d       = 1'b0;

        if (estado_q == ST_IDLE) begin
            // Deactivation wins when both requests arrive together
            if (desativar_in || atualizar_in) begin
                estado_d  = desativar_in ? ST_ESPERA_DES : ST_ESPERA_ATU;
                adr_reg_d = endereco_in;
                cnt_to_d  = '0;
            end
        end else if (estado_q == ST_ESPERA_ATU || estado_q == ST_ESPERA_DES) begin
            if (habilitar_in == '0) begin
                if (cnt_to_q == TO_MAX) begin
                    estado_d = ST_IDLE;
                    erro_d   = 1'b1;
                    cnt_to_d = '0;
                end else begin
                    cnt_to_d = cnt_to_q + TO_WIDTH'(1);
                end
            end else begin
                estado_d = ST_IDLE;
                if (!$onehot(habilitar_in)) begin
                    erro_d = 1'b1;
                end else if (estado_q == ST_ESPERA_ATU) begin
                    if (!slot_ativo) begin
                        for (int i = 0; i < NUM_NA; i++) begin
                            if (habilitar_in[i]) begin
                                na_end_d[ADR_WIDTH*i +: ADR_WIDTH] = adr_reg_q;
                            end
                        end
                        na_ativo_d = na_ativo_q | habilitar_in;
                        if (num_ativos_q != CNT_MAX) begin
                            num_ativos_d = num_ativos_q + CNT_WIDTH'(1);
                        end
                        concluido_d = 1'b1;
                    end else if (slot_igual) begin
                        // Manager hit: the node is already registered in this slot
                        concluido_d = 1'b1;
                    end else begin
                        erro_d = 1'b1;
                    end
                end else begin
                    if (slot_ativo && slot_igual) begin
                        // The address field is kept; only the active flag is cleared
                        na_ativo_d = na_ativo_q & ~habilitar_in;
                        if (num_ativos_q != '0) begin
                            num_ativos_d = num_ativos_q - CNT_WIDTH'(1);
                        end
                        concluido_d = 1'b1;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
        end else begin
            estado_d = ST_IDLE;
        end

        ocupado_d = (estado_d != ST_IDLE);
    end

    // State and bank registers; asynchronous reset clears everything, including pending requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= ST_IDLE;
            adr_reg_q    <= '0;
            cnt_to_q     <= '0;
            na_end_q     <= '0;
            na_ativo_q   <= '0;
            num_ativos_q <= '0;
            ocupado_q    <= 1'b0;
            concluido_q  <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            adr_reg_q    <= adr_reg_d;
            cnt_to_q     <= cnt_to_d;
            na_end_q     <= na_end_d;
            na_ativo_q   <= na_ativo_d;
            num_ativos_q <= num_ativos_d;
            ocupado_q    <= ocupado_d;
            concluido_q  <= concluido_d;
            erro_q       <= erro_d;
        end
    end

    assign na_endereco_out = na_end_q;
    assign na_ativo_out    = na_ativo_q;
    assign num_ativos_out  = num_ativos_q;
    assign cheio_out       = &na_ativo_q;
    assign ocupado_out     = ocupado_q;
    assign concluido_out   = concluido_q;
    assign erro_out        = erro_q;

endmodule

// File: tb/tb_banco_nos_ativos.sv
// Bench for banco_nos_ativos: directed requests, expected pulses queued and checked by a monitor.
module tb_banco_nos_ativos;

    logic        clk;
    logic        rst_n;
    logic        atualizar_in;
    logic        desativar_in;
    logic [4:0]  endereco_in;
    logic [7:0]  habilitar_in;
    logic [39:0] na_endereco_out;
    logic [7:0]  na_ativo_out;
    logic [3:0]  num_ativos_out;
    logic        cheio_out;
    logic        ocupado_out;
    logic        concluido_out;
    logic        erro_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] kind;   // {concluido, erro}
        logic [7:0] ativo;
        logic [3:0] num;
        int         slot;
        logic [4:0] adr;
    } exp_t;

    exp_t fila[$];

    localparam logic [1:0] K_OK  = 2'b10;
    localparam logic [1:0] K_ERR = 2'b01;

    banco_nos_ativos #(
        .NUM_NA(8), .ADR_WIDTH(5), .TIMEOUT(15), .TO_WIDTH(4), .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .atualizar_in(atualizar_in),
        .desativar_in(desativar_in),
        .endereco_in(endereco_in),
        .habilitar_in(habilitar_in),
        .na_endereco_out(na_endereco_out),
        .na_ativo_out(na_ativo_out),
        .num_ativos_out(num_ativos_out),
        .cheio_out(cheio_out),
        .ocupado_out(ocupado_out),
        .concluido_out(concluido_out),
        .erro_out(erro_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nome, atual, esperado);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] ativo, input logic [3:0] num,
                        input int slot, input logic [4:0] adr);
        exp_t e;
        e.kind = kind; e.ativo = ativo; e.num = num; e.slot = slot; e.adr = adr;
        fila.push_back(e);
    endtask

    task automatic req(input logic atu, input logic des, input logic [4:0] adr);
        @(negedge clk);
        atualizar_in = atu;
        desativar_in = des;
        endereco_in  = adr;
        @(negedge clk);
        atualizar_in = 1'b0;
        desativar_in = 1'b0;
    endtask

    task automatic pulso_hab(input logic [7:0] h);
        @(negedge clk);
        habilitar_in = h;
        @(negedge clk);
        habilitar_in = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && fila.size() != 0; k++) @(negedge clk);
        chk("pending_pulses", fila.size(), 0);
    endtask

    // One request plus enable round trip, expected result pushed first
    task automatic op(input logic atu, input logic des, input logic [4:0] adr, input logic [7:0] h,
                      input logic [1:0] kind, input logic [7:0] ativo, input logic [3:0] num,
                      input int slot, input logic [4:0] sadr);
        push(kind, ativo, num, slot, sadr);
        req(atu, des, adr);
        chk("ocupado_during_wait", ocupado_out, 1);
        @(negedge clk);
        pulso_hab(h);
        drain();
    endtask

    // Monitor: every pulse must match the oldest expected entry
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (concluido_out || erro_out) begin
                if (fila.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got concluido=%0b erro=%0b expected none",
                             concluido_out, erro_out);
                end else begin
                    exp_t e;
                    e = fila.pop_front();
                    chk("pulse_kind", {concluido_out, erro_out}, e.kind);
                    chk("na_ativo", na_ativo_out, e.ativo);
                    chk("num_ativos", num_ativos_out, e.num);
                    chk("slot_adr", na_endereco_out[5*e.slot +: 5], e.adr);
                    chk("ocupado_after_op", ocupado_out, 0);
                    chk("cheio", cheio_out, (e.ativo == 8'hFF) ? 1 : 0);
                end
            end
        end
    end

    initial begin
        int edge_erro;
        rst_n        = 1'b0;
        atualizar_in = 1'b0;
        desativar_in = 1'b0;
        endereco_in  = '0;
        habilitar_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ativo", na_ativo_out, 0);
        chk("rst_num", num_ativos_out, 0);
        chk("rst_enderecos", na_endereco_out[31:0], 0);
        chk("rst_cheio", cheio_out, 0);
        chk("rst_ocupado", ocupado_out, 0);
        chk("rst_pulsos", {concluido_out, erro_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Update into free slot, hit, deactivate
        op(1, 0, 5'h0A, 8'h04, K_OK,  8'h04, 4'd1, 2, 5'h0A);
        op(1, 0, 5'h0A, 8'h04, K_OK,  8'h04, 4'd1, 2, 5'h0A);
        op(0, 1, 5'h0A, 8'h04, K_OK,  8'h00, 4'd0, 2, 5'h0A);

        // Rejections
        op(0, 1, 5'h11, 8'h04, K_ERR, 8'h00, 4'd0, 2, 5'h0A);
        op(1, 0, 5'h03, 8'h05, K_ERR, 8'h00, 4'd0, 0, 5'h00);
        op(1, 0, 5'h03, 8'h01, K_OK,  8'h01, 4'd1, 0, 5'h03);
        op(1, 0, 5'h07, 8'h01, K_ERR, 8'h01, 4'd1, 0, 5'h03);

        // Timeout: erro 16 edges after the request edge
        push(K_ERR, 8'h01, 4'd1, 0, 5'h03);
        req(0, 1, 5'h03);
        edge_erro = 0;
        for (int k = 1; k <= 20 && edge_erro == 0; k++) begin
            @(posedge clk);
            #1;
            if (erro_out) edge_erro = k;
        end
        chk("timeout_edge", edge_erro, 16);
        @(negedge clk);
        chk("ocupado_after_timeout", ocupado_out, 0);
        drain();
        op(1, 0, 5'h0A, 8'h04, K_OK,  8'h05, 4'd2, 2, 5'h0A);

        // Fill remaining slots
        op(1, 0, 5'h11, 8'h02, K_OK,  8'h07, 4'd3, 1, 5'h11);
        op(1, 0, 5'h13, 8'h08, K_OK,  8'h0F, 4'd4, 3, 5'h13);
        op(1, 0, 5'h14, 8'h10, K_OK,  8'h1F, 4'd5, 4, 5'h14);
        op(1, 0, 5'h15, 8'h20, K_OK,  8'h3F, 4'd6, 5, 5'h15);
        op(1, 0, 5'h16, 8'h40, K_OK,  8'h7F, 4'd7, 6, 5'h16);
        op(1, 0, 5'h1F, 8'h80, K_OK,  8'hFF, 4'd8, 7, 5'h1F);
        chk("cheio_full", cheio_out, 1);
        chk("num_full", num_ativos_out, 8);

        // Both requests together: deactivation is taken
        op(1, 1, 5'h0A, 8'h04, K_OK,  8'hFB, 4'd7, 2, 5'h0A);
        chk("cheio_after_des", cheio_out, 0);

        // Enable while idle is ignored
        pulso_hab(8'h04);
        repeat (3) @(negedge clk);
        chk("idle_hab_ativo", na_ativo_out, 8'hFB);
        chk("idle_hab_num", num_ativos_out, 7);
        chk("idle_hab_pulsos", {concluido_out, erro_out}, 0);

        // Reset in the middle of an update request
        req(1, 0, 5'h15);
        chk("ocupado_before_reset", ocupado_out, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ativo", na_ativo_out, 0);
        chk("midrst_num", num_ativos_out, 0);
        chk("midrst_ocupado", ocupado_out, 0);
        chk("midrst_cheio", cheio_out, 0);
        chk("midrst_enderecos", na_endereco_out[31:0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulso_hab(8'h10);
        repeat (3) @(negedge clk);
        chk("after_rst_ativo", na_ativo_out, 0);
        chk("after_rst_num", num_ativos_out, 0);
        chk("after_rst_ocupado", ocupado_out, 0);

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
